// File: rtl/a2d_scan_ctrl.sv
// Periodic multi-channel A2D scan controller.
// Converts each masked channel once per scan period and keeps the last result per channel.
module a2d_scan_ctrl #(
    parameter int PERIOD_W = 16,
    parameter int TO_W     = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [7:0]          ch_mask,
    input  logic [PERIOD_W-1:0] scan_period,
    output logic                strt_cnv,
    output logic [2:0]          chnnl,
    input  logic                cnv_cmplt,
    input  logic [15:0]         res,
    input  logic [2:0]          rd_ch,
    output logic [11:0]         rd_data,
    output logic [7:0]          data_vld,
    output logic                scan_done,
    output logic                busy,
    output logic                to_err,
    input  logic                clr_err
);

    typedef enum logic [2:0] {IDLE, WAIT, START, CONV, NEXT} state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [7:0]          mask_q, mask_d;
    logic [2:0]          idx_q, idx_d;
    logic [2:0]          ch_q, ch_d;
    logic [7:0]          vld_q, vld_d;
    logic                err_q, err_d;
    logic [11:0]         result_q [8];
    logic                wr_en;
    logic                wrap;
    logic [7:0]          cand;
    logic                found;
    logic [2:0]          sel;
    logic                unused_res;

    assign unused_res = ^res[15:12];

    // Periods of 0 and 1 both wrap every clock, giving back-to-back scans.
    assign wrap = (scan_period <= PERIOD_W'(1)) ||
                  (per_q >= scan_period - PERIOD_W'(1));

    always_comb begin
        cand  = mask_q & (8'hFF << idx_q);
        found = 1'b0;
        sel   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cand[i]) begin
                found = 1'b1;
                sel   = 3'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        to_d      = to_q;
        mask_d    = mask_q;
        idx_d     = idx_q;
        ch_d      = ch_q;
        vld_d     = vld_q;
        err_d     = err_q & ~clr_err;
        wr_en     = 1'b0;
        strt_cnv  = 1'b0;
        scan_done = 1'b0;

        if (en) per_d = wrap ? '0 : per_q + PERIOD_W'(1);

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = START;
                    per_d   = '0;
                    mask_d  = ch_mask;
                    idx_d   = 3'd0;
                end
            end
            WAIT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (wrap) begin
                    state_d = START;
                    mask_d  = ch_mask;
                end
            end
            START: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (found) begin
                    strt_cnv = 1'b1;
                    ch_d     = sel;
                    idx_d    = sel;
                    to_d     = '0;
                    state_d  = CONV;
                end else begin
                    state_d = NEXT;
                end
            end
            CONV: begin
                // A completion arriving on the last timeout clock still counts.
                if (cnv_cmplt) begin
                    wr_en        = 1'b1;
                    vld_d[ch_q]  = 1'b1;
                    mask_d[ch_q] = 1'b0;
                    state_d      = en ? START : IDLE;
                end else if (&to_q) begin
                    err_d        = 1'b1;
                    mask_d[ch_q] = 1'b0;
                    state_d      = en ? START : IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            NEXT: begin
                scan_done = 1'b1;
                idx_d     = 3'd0;
                state_d   = en ? WAIT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            per_q   <= '0;
            to_q    <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            ch_q    <= '0;
            vld_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            to_q    <= to_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            ch_q    <= ch_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) result_q[i] <= '0;
        end else if (wr_en) begin
            result_q[ch_q] <= res[11:0];
        end
    end

    assign chnnl    = (state_q == START) ? sel : ch_q;
    assign busy     = (state_q == START) || (state_q == CONV) ||
                      (state_q == NEXT);
    assign data_vld = vld_q;
    assign to_err   = err_q;
    assign rd_data  = result_q[rd_ch];

endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Directed bench for a2d_scan_ctrl with a simple A2D responder model.
// Responder answers 8 clocks after each strt_cnv; TO_W=4 gives a 16-clock timeout.
module tb_a2d_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic [15:0] scan_period = 16'd0;
    logic        cnv_cmplt = 1'b0;
    logic [15:0] res = 16'h0000;
    logic [2:0]  rd_ch = 3'd0;
    logic        clr_err = 1'b0;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic [11:0] rd_data;
    logic [7:0]  data_vld;
    logic        scan_done;
    logic        busy;
    logic        to_err;

    a2d_scan_ctrl #(.PERIOD_W(16), .TO_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask),
        .scan_period(scan_period), .strt_cnv(strt_cnv), .chnnl(chnnl),
        .cnv_cmplt(cnv_cmplt), .res(res), .rd_ch(rd_ch),
        .rd_data(rd_data), .data_vld(data_vld), .scan_done(scan_done),
        .busy(busy), .to_err(to_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A2D model
    bit resp_on = 1'b1;
    int dly = 8;
    int cd = 0;
    always @(posedge clk) begin
        cnv_cmplt <= 1'b0;
        if (strt_cnv && resp_on) cd <= dly;
        else if (cd == 1) begin
            cnv_cmplt <= 1'b1;
            cd <= 0;
        end else if (cd > 1) cd <= cd - 1;
    end

    // Event monitor
    int cyc = 0, strt_cnt = 0, done_cnt = 0;
    int last_done = 0, prev_done = 0, strt_cyc = 0;
    logic [2:0] ch_log[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (strt_cnv) begin
            strt_cnt <= strt_cnt + 1;
            strt_cyc <= cyc;
            ch_log.push_back(chnnl);
        end
        if (scan_done) begin
            done_cnt  <= done_cnt + 1;
            prev_done <= last_done;
            last_done <= cyc;
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strt(int target, int maxc);
        int k = 0;
        while (strt_cnt < target && k < maxc) begin
            @(negedge clk);
            k++;
        end
        if (strt_cnt < target) check("wait_strt", strt_cnt, target);
    endtask

    int bs, bd, sc, run, maxrun, k;

    initial begin
        res = 16'hFABC;
        tick(3);
        check("rst_strt", strt_cnv, 0);
        check("rst_chnnl", chnnl, 0);
        check("rst_done", scan_done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", to_err, 0);
        check("rst_vld", data_vld, 8'h00);
        check("rst_rd", rd_data, 12'h000);
        rst_n = 1'b1;
        tick(2);

        // Two-channel periodic scan
        ch_mask = 8'h05; scan_period = 16'd100; en = 1'b1;
        tick(250);
        check("a_strt_n", strt_cnt, 6);
        check("a_ch0", ch_log[0], 0);
        check("a_ch1", ch_log[1], 2);
        check("a_ch3", ch_log[3], 2);
        check("a_vld", data_vld, 8'h05);
        rd_ch = 3'd2; #1;
        check("a_rd2", rd_data, 12'hABC);
        rd_ch = 3'd1; #1;
        check("a_rd1", rd_data, 12'h000);
        check("a_done_n", done_cnt, 3);
        check("a_period", last_done - prev_done, 100);
        en = 1'b0;
        tick(3);
        check("a_idle", busy, 0);

        // Empty mask
        bs = strt_cnt; bd = done_cnt;
        ch_mask = 8'h00; scan_period = 16'd20; en = 1'b1;
        run = 0; maxrun = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            run = busy ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        check("b_strt", strt_cnt - bs, 0);
        check("b_done_n", done_cnt - bd, 4);
        check("b_period", last_done - prev_done, 20);
        check("b_busy", maxrun, 2);
        en = 1'b0;
        tick(3);

        // Timeout
        resp_on = 1'b0;
        bs = strt_cnt; bd = done_cnt;
        ch_mask = 8'h30; scan_period = 16'd200; en = 1'b1;
        wait_strt(bs + 1, 20);
        sc = strt_cyc;
        k = 0;
        while (!to_err && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("c_to_lat", cyc - sc, 17);
        wait_strt(bs + 2, 10);
        check("c_ch4", ch_log[bs], 4);
        check("c_ch5", ch_log[bs+1], 5);
        tick(40);
        check("c_vld", data_vld, 8'h05);
        rd_ch = 3'd4; #1;
        check("c_rd4", rd_data, 12'h000);
        check("c_done", done_cnt - bd, 1);
        en = 1'b0;
        tick(2);
        check("c_err", to_err, 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("c_clr", to_err, 0);

        // en dropped during channel 3 conversion
        resp_on = 1'b1; res = 16'h1123;
        bs = strt_cnt; bd = done_cnt;
        ch_mask = 8'hFF; scan_period = 16'd300; en = 1'b1;
        wait_strt(bs + 4, 60);
        en = 1'b0;
        tick(30);
        check("d_strt_n", strt_cnt - bs, 4);
        check("d_ch3", ch_log[bs+3], 3);
        check("d_vld", data_vld, 8'h0F);
        rd_ch = 3'd3; #1;
        check("d_rd3", rd_data, 12'h123);
        check("d_done", done_cnt - bd, 0);
        check("d_idle", busy, 0);

        // Reset during conversion
        bs = strt_cnt;
        ch_mask = 8'h02; en = 1'b1;
        wait_strt(bs + 1, 20);
        tick(2);
        rst_n = 1'b0; en = 1'b0; #1;
        check("e_busy", busy, 0);
        check("e_strt", strt_cnv, 0);
        check("e_chnnl", chnnl, 0);
        check("e_vld", data_vld, 8'h00);
        check("e_err", to_err, 0);
        rd_ch = 3'd3; #1;
        check("e_rd3", rd_data, 12'h000);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("e_late_vld", data_vld, 8'h00);
        check("e_late_busy", busy, 0);
        rd_ch = 3'd1; #1;
        check("e_late_rd", rd_data, 12'h000);

        // Scan longer than the period
        res = 16'h2456;
        bd = done_cnt;
        ch_mask = 8'h70; scan_period = 16'd10; en = 1'b1;
        tick(100);
        check("f_done_n", done_cnt - bd, 2);
        check("f_period", last_done - prev_done, 40);
        check("f_vld", data_vld, 8'h70);
        rd_ch = 3'd6; #1;
        check("f_rd6", rd_data, 12'h456);
        en = 1'b0;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
